// File: rtl/aes_package.sv
// Shared types and constants for the AES stream deserializer slice:
// control/flag structs, block geometry and the deserializer FSM states.
package aes_package;

    localparam int BEATS_PER_BLOCK = 4;
    localparam int BLOCK_W         = 128;
    localparam int BEAT_W          = BLOCK_W / BEATS_PER_BLOCK;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_BLOCK - 1);

    typedef struct packed {
        logic        enable;
        logic [15:0] len;
    } ctrl_deser_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [15:0] blk_cnt;
        logic        strb_err;
    } flags_deser_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } deser_state_e;

endpackage

// File: rtl/aes_stream_deserializer_if.sv
// Valid/ready word stream with byte strobes; the producer uses the source
// modport and the deserializer consumes through the sink modport.
interface hwpe_stream_intf_stream #(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    valid;
    logic                    ready;

    modport source (
        output data,
        output strb,
        output valid,
        input  ready
    );

    modport sink (
        input  data,
        input  strb,
        input  valid,
        output ready
    );

endinterface

// File: rtl/aes_block_fifo.sv
// DEPTH-entry block FIFO with wrap-bit pointers; the head reads as zero
// while empty so the block output is clean after a flush.
module aes_block_fifo
    import aes_package::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = BLOCK_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : r_mem[r_rptr[AW-1:0]];

    // The extra MSB on each pointer distinguishes full from empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/aes_stream_deserializer.sv
// Collects four 32b beats into a 128b block (first beat least significant),
// queues blocks in a small FIFO and tracks job progress through IDLE/RUN/DONE.
module aes_stream_deserializer
    import aes_package::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    hwpe_stream_intf_stream.sink   d_i,
    input  ctrl_deser_t            ctrl_i,
    output logic [BLOCK_W-1:0]     block_o,
    output logic                   block_valid_o,
    input  logic                   block_ready_i,
    output flags_deser_t           flags_o
);

    deser_state_e       r_state;
    logic [1:0]         r_beat_cnt;
    logic [BLOCK_W-1:0] r_asm;
    logic               r_push;
    logic               r_done;
    logic               r_strb_err;
    logic [15:0]        r_len;
    logic [15:0]        r_blk_cnt;

    logic               w_flush;
    logic               w_ready;
    logic               w_beat;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_last_push;
    logic [BLOCK_W-1:0] w_head;

    assign w_flush = rst_i || clear_i;

    // Only the last beat of a block can need a free FIFO slot, so ready is
    // held back just then; registered full keeps d_i off any pop path.
    assign w_ready = (r_state == ST_RUN) &&
                     !((r_beat_cnt == LAST_BEAT) && w_full);
    assign d_i.ready = w_ready;
    assign w_beat    = d_i.valid && w_ready;
    assign w_pop     = block_valid_o && block_ready_i;

    assign block_valid_o = !w_empty;
    assign block_o       = w_head;

    assign w_last_push = r_push &&
                         (({1'b0, r_blk_cnt} + 17'd1) == {1'b0, r_len});

    aes_block_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BLOCK_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (w_flush),
        .push_i  (r_push),
        .data_i  (r_asm),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (w_beat) begin
            r_asm[{r_beat_cnt, 5'd0} +: BEAT_W] <= d_i.data;
        end
    end

    // Clearing the beat counter on flush drops any partly assembled block.
    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_push     <= 1'b0;
            r_done     <= 1'b0;
            r_strb_err <= 1'b0;
            r_len      <= '0;
            r_blk_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            r_push <= w_beat && (r_beat_cnt == LAST_BEAT);
            if (r_push && (r_blk_cnt != 16'hFFFF)) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 2'd1;
                if (d_i.strb != 4'hF) begin
                    r_strb_err <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_i.enable) begin
                        if (ctrl_i.len != '0) begin
                            r_state    <= ST_RUN;
                            r_len      <= ctrl_i.len;
                            r_blk_cnt  <= '0;
                            r_strb_err <= 1'b0;
                            r_beat_cnt <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_last_push) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_empty && !ctrl_i.enable) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        flags_o          = '0;
        flags_o.busy     = (r_state == ST_RUN) || !w_empty;
        flags_o.done     = r_done;
        flags_o.blk_cnt  = r_blk_cnt;
        flags_o.strb_err = r_strb_err;
    end

endmodule

// File: tb/tb_aes_stream_deserializer.sv
// Drives random word streams into the deserializer and compares every cycle
// against a queue-based model of jobs, blocks and flags.
module tb_aes_stream_deserializer;
    import aes_package::*;

    localparam int DEPTH   = 2;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               blockReady;
    ctrl_deser_t        ctrl;
    logic [BLOCK_W-1:0] blockOut;
    logic               blockValid;
    flags_deser_t       flags;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) dIf ();

    aes_stream_deserializer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .d_i           (dIf),
        .ctrl_i        (ctrl),
        .block_o       (blockOut),
        .block_valid_o (blockValid),
        .block_ready_i (blockReady),
        .flags_o       (flags)
    );

    int           checks = 0;
    int           errors = 0;
    bit           checkEn = 0;
    beat_t        txQ[$];
    int           gapPct = 0;
    bit           randReady = 0;
    bit           beatTaken = 0;
    int           cyc = 0;

    int           mPhase = PH_IDLE;
    int           mLen = 0;
    int           mBlkCnt = 0;
    bit           mDone = 0;
    bit           mStrbErr = 0;
    bit           mPend = 0;
    logic [127:0] mStage = '0;
    logic [31:0]  mPart[$];
    logic [127:0] mExpQ[$];

    int           beatsAccepted = 0;
    int           doneSeen = 0;
    int           firstBeatCyc = 0;
    int           lastBeatCyc = 0;
    bit           armFirst = 0;
    bit           busyEver = 0;
    logic [127:0] gotQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [127:0] gotAt(input int idx);
        return (idx >= 0 && gotQ.size() > idx) ? gotQ[idx] : '0;
    endfunction

    // Compare this cycle's outputs, then advance the job model across the next edge.
    task automatic modelStep();
        logic         predReady;
        logic         predValid;
        logic [127:0] predBlock;
        logic         beatX;
        logic         popX;
        logic         wasEmpty;
        logic         nextDone;
        predReady = (mPhase == PH_RUN) && !(mPart.size() == 3 && mExpQ.size() == DEPTH);
        predValid = (mExpQ.size() != 0);
        predBlock = predValid ? mExpQ[0] : '0;
        if (checkEn) begin
            checkOutput("ready", dIf.ready, predReady);
            checkOutput("blockValid", blockValid, predValid);
            checkOutput("blockData", blockOut, predBlock);
            checkOutput("busy", flags.busy, (mPhase == PH_RUN) || predValid);
            checkOutput("done", flags.done, mDone);
            checkOutput("blkCnt", flags.blk_cnt, mBlkCnt);
            checkOutput("strbErr", flags.strb_err, mStrbErr);
            if (flags.busy) busyEver = 1;
            if (flags.done) doneSeen++;
        end
        beatTaken = 0;
        if (rst || clear) begin
            mPhase = PH_IDLE; mLen = 0; mBlkCnt = 0; mDone = 0;
            mStrbErr = 0; mPend = 0;
            mPart.delete();
            mExpQ.delete();
            return;
        end
        if (dIf.valid && dIf.ready) begin
            beatTaken = 1;
            beatsAccepted++;
            lastBeatCyc = cyc;
            if (armFirst) begin
                firstBeatCyc = cyc;
                armFirst = 0;
            end
        end
        if (blockValid && blockReady) gotQ.push_back(blockOut);
        beatX    = dIf.valid && predReady;
        popX     = predValid && blockReady;
        wasEmpty = !predValid;
        nextDone = 0;
        if (popX) mExpQ.delete(0);
        if (mPend) begin
            mExpQ.push_back(mStage);
            if (mBlkCnt < 65535) mBlkCnt++;
        end
        case (mPhase)
            PH_IDLE: begin
                if (ctrl.enable) begin
                    if (ctrl.len != 0) begin
                        mPhase = PH_RUN; mLen = ctrl.len; mBlkCnt = 0;
                        mStrbErr = 0;
                        mPart.delete();
                    end else begin
                        nextDone = 1;
                    end
                end
            end
            PH_RUN: begin
                if (mPend && mBlkCnt == mLen) begin
                    mPhase = PH_DONE;
                    nextDone = 1;
                end
            end
            default: begin
                if (wasEmpty && !ctrl.enable) mPhase = PH_IDLE;
            end
        endcase
        mPend = 0;
        if (beatX) begin
            mPart.push_back(dIf.data);
            if (dIf.strb != 4'hF) mStrbErr = 1;
            if (mPart.size() == 4) begin
                mStage = {mPart[3], mPart[2], mPart[1], mPart[0]};
                mPend = 1;
                mPart.delete();
            end
        end
        mDone = nextDone;
    endtask

    initial begin : feederMonitor
        forever begin
            @(negedge clk);
            cyc++;
            if (beatTaken && txQ.size() != 0) txQ.delete(0);
            if (randReady) blockReady = 1'($urandom_range(1));
            if (txQ.size() != 0 && ((dIf.valid && !beatTaken) || $urandom_range(99) >= gapPct)) begin
                dIf.valid = 1'b1;
                dIf.data  = txQ[0].data;
                dIf.strb  = txQ[0].strb;
            end else begin
                dIf.valid = 1'b0;
                dIf.data  = $urandom;
                dIf.strb  = 4'hF;
            end
            #2;
            modelStep();
        end
    end

    task automatic driveWait();
        @(negedge clk);
        #1;
    endtask

    task automatic queueBeat(input logic [31:0] data, input logic [3:0] strb);
        beat_t b;
        b.data = data;
        b.strb = strb;
        txQ.push_back(b);
    endtask

    task automatic applyStimulus(input int len);
        driveWait();
        ctrl.enable = 1'b1;
        ctrl.len    = 16'(len);
        driveWait();
        ctrl.enable = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (!(mPhase == PH_IDLE && mExpQ.size() == 0 && txQ.size() == 0 && !mPend)
               && n < budget) begin
            driveWait();
            n++;
        end
        checkOutput("waitIdle", (n >= budget), 1'b0);
    endtask

    task automatic waitBeats(input int base, input int count, input int budget);
        int n = 0;
        while (beatsAccepted - base < count && n < budget) begin
            driveWait();
            n++;
        end
        checkOutput("waitBeats", (n >= budget), 1'b0);
    endtask

    initial begin : mainSequence
        logic [31:0] w[32];
        int g0, b0, d0, len;
        bit anyErr;
        rst = 1; clear = 0; blockReady = 0; ctrl = '0;
        dIf.valid = 0; dIf.data = '0; dIf.strb = '0;
        repeat (3) @(negedge clk);
        checkEn = 1;
        #1;
        rst = 0;
        checkOutput("resetReady", dIf.ready, 0);
        checkOutput("resetValid", blockValid, 0);
        checkOutput("resetBlock", blockOut, 0);
        checkOutput("resetDone", flags.done, 0);
        checkOutput("resetBlkCnt", flags.blk_cnt, 0);
        checkOutput("resetBusy", flags.busy, 0);

        blockReady = 1;
        g0 = gotQ.size(); d0 = doneSeen;
        queueBeat(32'h00112233, 4'hF);
        queueBeat(32'h44556677, 4'hF);
        queueBeat(32'h8899AABB, 4'hF);
        queueBeat(32'hCCDDEEFF, 4'hF);
        applyStimulus(1);
        waitIdle(200);
        checkOutput("singleCount", gotQ.size() - g0, 1);
        checkOutput("singleBlock", gotAt(g0), 128'hCCDDEEFF_8899AABB_44556677_00112233);
        checkOutput("singleDone", doneSeen - d0, 1);
        checkOutput("singleBlkCnt", flags.blk_cnt, 1);

        blockReady = 0;
        g0 = gotQ.size(); b0 = beatsAccepted;
        for (int i = 0; i < 16; i++) begin
            w[i] = $urandom;
            queueBeat(w[i], 4'hF);
        end
        applyStimulus(4);
        waitBeats(b0, 11, 80);
        repeat (4) driveWait();
        checkOutput("bpBeats", beatsAccepted - b0, 11);
        checkOutput("bpReady", dIf.ready, 0);
        checkOutput("bpValid", blockValid, 1);
        blockReady = 1;
        waitIdle(300);
        checkOutput("bpCount", gotQ.size() - g0, 4);
        for (int k = 0; k < 4; k++)
            checkOutput("bpBlock", gotAt(g0 + k), {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]});
        checkOutput("bpBlkCnt", flags.blk_cnt, 4);

        d0 = doneSeen; b0 = beatsAccepted; busyEver = 0;
        queueBeat($urandom, 4'hF);
        applyStimulus(0);
        repeat (3) driveWait();
        checkOutput("zeroDone", doneSeen - d0, 1);
        checkOutput("zeroBeats", beatsAccepted - b0, 0);
        checkOutput("zeroBusy", busyEver, 0);
        txQ.delete();
        driveWait();

        g0 = gotQ.size();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            queueBeat(w[i], (i == 1) ? 4'h7 : 4'hF);
        end
        applyStimulus(1);
        waitIdle(200);
        checkOutput("seBlock", gotAt(g0), {w[3], w[2], w[1], w[0]});
        repeat (2) driveWait();
        checkOutput("seHeld", flags.strb_err, 1);
        for (int i = 0; i < 4; i++) queueBeat($urandom, 4'hF);
        applyStimulus(1);
        checkOutput("seCleared", flags.strb_err, 0);
        waitIdle(200);

        g0 = gotQ.size(); b0 = beatsAccepted;
        queueBeat($urandom, 4'hF);
        queueBeat($urandom, 4'hF);
        applyStimulus(1);
        waitBeats(b0, 2, 40);
        rst = 1;
        txQ.delete();
        driveWait();
        rst = 0;
        repeat (3) driveWait();
        checkOutput("rmNoBlock", gotQ.size() - g0, 0);
        checkOutput("rmValid", blockValid, 0);
        checkOutput("rmBlkCnt", flags.blk_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            queueBeat(w[i], 4'hF);
        end
        applyStimulus(1);
        waitIdle(200);
        checkOutput("rmCount", gotQ.size() - g0, 1);
        checkOutput("rmBlock", gotAt(g0), {w[3], w[2], w[1], w[0]});

        blockReady = 0;
        g0 = gotQ.size(); b0 = beatsAccepted;
        for (int i = 0; i < 8; i++) queueBeat($urandom, 4'hF);
        applyStimulus(2);
        waitBeats(b0, 5, 60);
        clear = 1;
        txQ.delete();
        driveWait();
        clear = 0;
        checkOutput("clrValid", blockValid, 0);
        checkOutput("clrBusy", flags.busy, 0);
        checkOutput("clrReady", dIf.ready, 0);
        blockReady = 1;
        repeat (3) driveWait();
        checkOutput("clrNoBlock", gotQ.size() - g0, 0);

        blockReady = 1; gapPct = 0;
        g0 = gotQ.size();
        for (int i = 0; i < 32; i++) begin
            w[i] = $urandom;
            queueBeat(w[i], 4'hF);
        end
        armFirst = 1;
        applyStimulus(8);
        waitIdle(400);
        checkOutput("stCount", gotQ.size() - g0, 8);
        checkOutput("stSpan", lastBeatCyc - firstBeatCyc, 31);
        checkOutput("stBlkCnt", flags.blk_cnt, 8);
        for (int k = 0; k < 8; k++)
            checkOutput("stBlock", gotAt(g0 + k), {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]});

        for (int j = 0; j < 6; j++) begin
            len = $urandom_range(1, 4);
            gapPct = $urandom_range(0, 40);
            randReady = 1;
            anyErr = 0;
            g0 = gotQ.size();
            for (int i = 0; i < 4 * len; i++) begin
                logic [3:0] s;
                s = ($urandom_range(9) == 0) ? 4'($urandom) : 4'hF;
                if (s != 4'hF) anyErr = 1;
                queueBeat($urandom, s);
            end
            applyStimulus(len);
            waitIdle(1500);
            randReady = 0;
            blockReady = 1;
            checkOutput("rnCount", gotQ.size() - g0, len);
            checkOutput("rnBlkCnt", flags.blk_cnt, len);
            checkOutput("rnStrbErr", flags.strb_err, anyErr);
        end
        gapPct = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/aes_stream_deserializer.md
AES_STREAM_DESERIALIZER -- requirements
Module: aes_stream_deserializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of 128b blocks held in the output FIFO (power of two, >=2).
REQ-002 SHALL have port clk_i  in  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port clear_i  in  1  synchronous soft flush, same effect as rst_i.
REQ-005 SHALL have port d_i  hwpe_stream_intf_stream.sink  32b data/4b strb/valid/ready  the word stream from the engine.
REQ-006 SHALL have port ctrl_i  in  ctrl_deser_t  {enable, len[15:0]}, where len is the number of blocks in the job.
REQ-007 SHALL have port block_o  out  128  the head FIFO block.
REQ-008 SHALL have port block_valid_o  out  1  block_o holds valid data.
REQ-009 SHALL have port block_ready_i  in  1  the consumer accepts block_o.
REQ-010 SHALL have port flags_o  out  flags_deser_t  {busy, done, blk_cnt[15:0], strb_err}.

Function
REQ-011 SHALL use a beat transfer on d_i.valid && d_i.ready, and a block transfer on block_valid_o && block_ready_i.
REQ-012 SHALL hold states IDLE, RUN and DONE.
- IDLE->RUN on ctrl_i.enable && len!=0.
- RUN->DONE in the cycle after the len-th block is pushed.
- DONE->IDLE when the FIFO is empty and enable is low.
REQ-013 SHALL pulse flags_o.done high for exactly one cycle on entry to DONE; with enable && len==0 in IDLE, it SHALL pulse done in the next cycle and stay in IDLE.
REQ-014 SHALL place beat k (0..3) of a block at block bits [32k+31:32k], i.e. the first beat is least significant.
REQ-015 SHALL use a 2-bit beat counter that wraps 3->0 on each beat and pushes the assembled block into the FIFO in the cycle after the 4th beat (push latency 1).
REQ-016 SHALL drive d_i.ready = (state==RUN) && !(beat_cnt==3 && fifo_full), using registered full only; a pop in the same cycle SHALL NOT raise ready.
REQ-017 SHALL hold d_i.ready low in IDLE and DONE; beats presented there SHALL NOT be accepted.
REQ-018 SHALL drive block_valid_o = !fifo_empty and block_o = FIFO head, with no combinational path from d_i to block_o.
REQ-019 SHALL leave occupancy unchanged on a simultaneous push and pop with the FIFO neither empty nor full; wrap-around of the read and write pointers SHALL be modulo DEPTH.
REQ-020 SHALL, for a beat with strb != 4'hF, accept the data unchanged and set flags_o.strb_err sticky until reset, clear or the next IDLE->RUN.
REQ-021 SHALL increment flags_o.blk_cnt per block pushed, clear it on IDLE->RUN, and never wrap within a job.
REQ-022 SHALL drive flags_o.busy = (state==RUN) || !fifo_empty.
REQ-023 SHALL, if enable drops in RUN, finish the current job; enable is sampled only in IDLE.

Reset
REQ-024 SHALL, on rst_i or clear_i, put state to IDLE, clear beat_cnt, blk_cnt, the FIFO pointers and strb_err, and drive d_i.ready=0, block_valid_o=0, block_o=0 and done=0 from the next cycle.
REQ-025 SHALL, on reset mid-block, discard partially assembled beats and never emit them.
REQ-026 SHALL give rst_i and clear_i priority over any concurrent transfer.

Structure
REQ-027 SHALL define ctrl_deser_t, flags_deser_t, BEATS_PER_BLOCK=4 and BLOCK_W=128 in aes_package.
REQ-028 SHALL implement the block FIFO as one sub-module, aes_block_fifo (DEPTH x BLOCK_W, with full/empty outputs).
REQ-029 SHALL keep the FSM, beat assembly and flags in the top module.

Verification
REQ-030 SHALL cover this single-block case: len=1, beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> block_o=0xCCDDEEFF_8899AABB_44556677_00112233, done pulses once, blk_cnt=1.
REQ-031 SHALL cover backpressure: len=4, block_ready_i=0 -> after 2 blocks plus 3 beats, d_i.ready=0; raising block_ready_i resumes the stream, and all 4 blocks come out in order.
REQ-032 SHALL cover len=0 with enable=1 -> done pulses 1 cycle later, no beat is accepted, and busy stays 0.
REQ-033 SHALL cover a strobe error: 2nd beat with strb=4'h7 -> data passes unmodified, strb_err=1 until the next job start.
REQ-034 SHALL cover reset mid-block: rst_i after 2 beats -> no block is emitted, and a following len=1 job produces the correct block from fresh beats.
REQ-035 SHALL cover streaming: DEPTH=2, len=8, continuous valid and block_ready_i=1 -> one beat accepted every cycle, 8 blocks delivered, and blk_cnt=8.
